// File: rtl/game_state_ctrl.sv
// game_state_ctrl: round/score controller for the tank game.
// Synchronises the frame strobe and the death/base flags, runs the
// IDLE/PLAY/RESPAWN/OVER game FSM, keeps lives and a two-digit BCD score,
// and issues one-cycle respawn pulses to the tank blocks.
// Optional feature macro: GSC_BONUS_LIFE_EN (one bonus life every 10th kill,
// capped at MAX_LIVES). The default build has no bonus lives.
module game_state_ctrl #(
  parameter logic [7:0] START_CODE    = 8'h29,
  parameter int         LIVES_INIT    = 3,
  parameter int         MAX_LIVES     = 7,
  parameter int         P_RESPAWN_FR  = 60,
  parameter int         AI_RESPAWN_FR = 90
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       tank_death,
  input  logic       ai_death,
  input  logic       base_hit,
  output logic [1:0] state,
  output logic       play_en,
  output logic       p_respawn,
  output logic       ai_respawn,
  output logic [2:0] lives,
  output logic [7:0] score,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;
  localparam logic [1:0] S_OVER = 2'b11;

  // Starting lives never exceed the ceiling, even with a mis-set parameter.
  localparam logic [2:0] LIVES_START = (LIVES_INIT > MAX_LIVES) ? 3'(MAX_LIVES) : 3'(LIVES_INIT);
  localparam logic [6:0] P_LOAD      = 7'(P_RESPAWN_FR);
  localparam logic [6:0] AI_LOAD     = 7'(AI_RESPAWN_FR);
`ifdef GSC_BONUS_LIFE_EN
  localparam logic [2:0] LIVES_CAP   = 3'(MAX_LIVES);
`endif

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)        return s;
    if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset synchroniser: asserts asynchronously, releases on a clock edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Bit order: {frame_clk, tank_death, ai_death, base_hit}.
  logic [3:0] raw_in;
  logic [3:0] sync1_q, sync2_q, sync3_q, edge_q;
  logic       key_match_q, key_prev_q;
  logic       frame_tick, tank_ev, ai_ev, base_ev, start_ev;

  assign raw_in = {frame_clk, tank_death, ai_death, base_hit};

  // Two-FF synchronisers plus registered rising-edge detect (3 Clk latency).
  always_ff @(posedge Clk or negedge rst_n) begin
    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value; blocking ones would collapse the pipeline.
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      edge_q      <= '0;
      key_match_q <= 1'b0;
      key_prev_q  <= 1'b0;
    end else begin
      sync1_q     <= raw_in;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      edge_q      <= sync2_q & ~sync3_q;
      key_match_q <= (keycode == START_CODE);
      key_prev_q  <= key_match_q;
    end
  end

  assign {frame_tick, tank_ev, ai_ev, base_ev} = edge_q;
  assign start_ev = key_match_q & ~key_prev_q;

  logic [1:0] state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [6:0] p_cnt_q, p_cnt_d;
  logic [6:0] ai_cnt_q, ai_cnt_d;
  logic       p_pulse_d, ai_pulse_d;
  logic       play_en_q, game_over_q, p_resp_q, ai_resp_q;

  // Next-state logic for the game FSM, counters, lives and score.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    p_cnt_d    = p_cnt_q;
    ai_cnt_d   = ai_cnt_q;
    p_pulse_d  = 1'b0;
    ai_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        ai_cnt_d = '0;
        p_cnt_d  = '0;
        if (start_ev) begin
          state_d    = S_PLAY;
          lives_d    = LIVES_START;
          score_d    = '0;
          p_pulse_d  = 1'b1;
          ai_pulse_d = 1'b1;
        end
      end

      S_PLAY, S_RESP: begin
        // AI respawn timer runs in both in-game states.
        if (frame_tick && ai_cnt_q != '0) begin
          ai_cnt_d   = ai_cnt_q - 7'd1;
          ai_pulse_d = (ai_cnt_q == 7'd1);
        end
        // A kill only counts while the AI is alive (timer idle).
        if (ai_ev && ai_cnt_q == '0) begin
          score_d  = bcd_inc(score_q);
          ai_cnt_d = AI_LOAD;
`ifdef GSC_BONUS_LIFE_EN
          if (score_d != score_q && score_d[3:0] == 4'd0 && lives_q < LIVES_CAP)
            lives_d = lives_q + 3'd1;
`endif
        end

        if (base_ev) begin
          state_d = S_OVER;
        end else if (state_q == S_PLAY) begin
          // Tank death acts on lives after any same-cycle bonus.
          if (tank_ev) begin
            if (lives_d == 3'd1) begin
              lives_d = 3'd0;
              state_d = S_OVER;
            end else begin
              lives_d = lives_d - 3'd1;
              p_cnt_d = P_LOAD;
              state_d = S_RESP;
            end
          end
        end else if (frame_tick && p_cnt_q != '0) begin
          p_cnt_d = p_cnt_q - 7'd1;
          if (p_cnt_q == 7'd1) begin
            p_pulse_d = 1'b1;
            state_d   = S_PLAY;
          end
        end
      end

      default: begin  // S_OVER: everything frozen until a restart key
        ai_cnt_d = '0;
        p_cnt_d  = '0;
        if (start_ev) begin
          state_d = S_IDLE;
          lives_d = '0;
          score_d = '0;
        end
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      p_cnt_q     <= '0;
      ai_cnt_q    <= '0;
      play_en_q   <= 1'b0;
      game_over_q <= 1'b0;
      p_resp_q    <= 1'b0;
      ai_resp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      p_cnt_q     <= p_cnt_d;
      ai_cnt_q    <= ai_cnt_d;
      play_en_q   <= (state_d == S_PLAY);
      game_over_q <= (state_d == S_OVER);
      p_resp_q    <= p_pulse_d;
      ai_resp_q   <= ai_pulse_d;
    end
  end

  assign state      = state_q;
  assign play_en    = play_en_q;
  assign game_over  = game_over_q;
  assign p_respawn  = p_resp_q;
  assign ai_respawn = ai_resp_q;
  assign lives      = lives_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: self-checking bench for game_state_ctrl.
// A table of post-game vectors plus hand-built sequences for scoring,
// respawn timing, saturation and reset; expectations come from a small
// lives/kills model and go through a scoreboard queue.
module tb_game_state_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;
  localparam logic [1:0] S_OVER = 2'b11;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       tank_death = 1'b0, ai_death = 1'b0, base_hit = 1'b0;
  logic [1:0] state;
  logic       play_en, p_respawn, ai_respawn, game_over;
  logic [2:0] lives;
  logic [7:0] score;

  game_state_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .tank_death(tank_death), .ai_death(ai_death), .base_hit(base_hit),
    .state(state), .play_en(play_en), .p_respawn(p_respawn), .ai_respawn(ai_respawn),
    .lives(lives), .score(score), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    bit         key, ai, tank, base;
    int         frames;
    logic [1:0] st;
    logic [2:0] lv;
    logic [7:0] sc;
    int         pp, ap;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[11];

  int n_vec = 0, n_miss = 0;
  int p_seen = 0, a_seen = 0, p_wide = 0, a_wide = 0;
  logic p_prev = 1'b0, a_prev = 1'b0;

  int         m_kills;
  logic [2:0] m_lives;

  // Respawn pulse counter and width monitor.
  always @(negedge Clk) begin
    if (p_respawn) p_seen <= p_seen + 1;
    if (ai_respawn) a_seen <= a_seen + 1;
    if (p_respawn && p_prev) p_wide <= p_wide + 1;
    if (ai_respawn && a_prev) a_wide <= a_wide + 1;
    p_prev <= p_respawn;
    a_prev <= ai_respawn;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    clk_wait(2);
    frame_clk = 1'b0;
    clk_wait(2);
  endtask

  function automatic vec_t mk(input string n, input bit key, input bit ai, input bit tank,
                              input bit base, input int fr, input logic [1:0] st,
                              input logic [2:0] lv, input logic [7:0] sc,
                              input int pp, input int ap);
    vec_t v;
    v.name = n; v.key = key; v.ai = ai; v.tank = tank; v.base = base; v.frames = fr;
    v.st = st; v.lv = lv; v.sc = sc; v.pp = pp; v.ap = ap;
    return v;
  endfunction

  function automatic logic [7:0] bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  // Kill model: score saturates at 99; optional bonus every 10th kill.
  task automatic model_kill();
    if (m_kills < 99) begin
      m_kills++;
`ifdef GSC_BONUS_LIFE_EN
      if (m_kills % 10 == 0 && m_lives < 3'd7) m_lives = m_lives + 3'd1;
`endif
    end
  endtask

  // Drive one vector, queue its expectation, then pop and compare.
  task automatic apply(input vec_t v);
    int   p0, a0;
    vec_t e;
    p0 = p_seen;
    a0 = a_seen;
    if (v.key) begin
      keycode = 8'h29;
      clk_wait(3);
      keycode = 8'h00;
    end
    if (v.ai || v.tank || v.base) begin
      ai_death = v.ai; tank_death = v.tank; base_hit = v.base;
      clk_wait(3);
      ai_death = 1'b0; tank_death = 1'b0; base_hit = 1'b0;
    end
    clk_wait(6);
    repeat (v.frames) frame_pulse();
    clk_wait(6);
    exp_q.push_back(v);
    e = exp_q.pop_front();
    check({e.name, " state"}, 32'(state), 32'(e.st));
    check({e.name, " lives"}, 32'(lives), 32'(e.lv));
    check({e.name, " score"}, 32'(score), 32'(e.sc));
    check({e.name, " play_en"}, 32'(play_en), 32'(e.st == S_PLAY));
    check({e.name, " game_over"}, 32'(game_over), 32'(e.st == S_OVER));
    check({e.name, " p_respawn count"}, 32'(p_seen - p0), 32'(e.pp));
    check({e.name, " ai_respawn count"}, 32'(a_seen - a0), 32'(e.ap));
  endtask

  initial begin
    tbl[0]  = mk("over_ai_ign",   0, 1, 0, 0,   0, S_OVER, 3'd0, 8'h99, 0, 0);
    tbl[1]  = mk("over_tank_ign", 0, 0, 1, 0,   0, S_OVER, 3'd0, 8'h99, 0, 0);
    tbl[2]  = mk("over_base_ign", 0, 0, 0, 1,  20, S_OVER, 3'd0, 8'h99, 0, 0);
    tbl[3]  = mk("over_to_idle",  1, 0, 0, 0,   0, S_IDLE, 3'd0, 8'h00, 0, 0);
    tbl[4]  = mk("idle_ev_ign",   0, 1, 1, 0, 100, S_IDLE, 3'd0, 8'h00, 0, 0);
    tbl[5]  = mk("idle_to_play",  1, 0, 0, 0,   0, S_PLAY, 3'd3, 8'h00, 1, 1);
    tbl[6]  = mk("simul_all",     0, 1, 1, 1,   0, S_OVER, 3'd3, 8'h01, 0, 0);
    tbl[7]  = mk("over_frozen",   0, 0, 0, 0, 100, S_OVER, 3'd3, 8'h01, 0, 0);
    tbl[8]  = mk("over_idle2",    1, 0, 0, 0,   0, S_IDLE, 3'd0, 8'h00, 0, 0);
    tbl[9]  = mk("play_again",    1, 0, 0, 0,   0, S_PLAY, 3'd3, 8'h00, 1, 1);
    tbl[10] = mk("kill_one",      0, 1, 0, 0,   0, S_PLAY, 3'd3, 8'h01, 0, 0);

    // Reset state.
    clk_wait(3);
    check("rst state", 32'(state), 32'(S_IDLE));
    check("rst lives", 32'(lives), 0);
    check("rst score", 32'(score), 0);
    check("rst play_en", 32'(play_en), 0);
    check("rst game_over", 32'(game_over), 0);
    Reset_n = 1'b1;
    clk_wait(4);

    m_kills = 0;
    m_lives = 3'd3;
    apply(mk("start", 1, 0, 0, 0, 0, S_PLAY, m_lives, 8'h00, 1, 1));

    // Twelve kills, each followed by a full AI respawn period.
    for (int i = 1; i <= 12; i++) begin
      model_kill();
      apply(mk($sformatf("kill%0d", i), 0, 1, 0, 0, 90, S_PLAY, m_lives, bcd(m_kills), 0, 1));
    end
    check("score after 12 kills", 32'(score), 32'h12);

    // Second kill 30 frames in is ignored; respawn lands on frame 90.
    model_kill();
    apply(mk("ai_kill_t0",    0, 1, 0, 0, 30, S_PLAY, m_lives, bcd(m_kills), 0, 0));
    apply(mk("ai_kill_dead",  0, 1, 0, 0, 59, S_PLAY, m_lives, bcd(m_kills), 0, 0));
    apply(mk("ai_respawn_90", 0, 0, 0, 0,  1, S_PLAY, m_lives, bcd(m_kills), 0, 1));

    // First tank death, with a kill landing during RESPAWN.
    m_lives = m_lives - 3'd1;
    apply(mk("tank_death1", 0, 0, 1, 0, 0, S_RESP, m_lives, bcd(m_kills), 0, 0));
    model_kill();
    apply(mk("resp_kill",   0, 1, 0, 0, 59, S_RESP, m_lives, bcd(m_kills), 0, 0));
    apply(mk("resp_60",     0, 0, 0, 0,  1, S_PLAY, m_lives, bcd(m_kills), 1, 0));
    apply(mk("resp_ai_90",  0, 0, 0, 0, 30, S_PLAY, m_lives, bcd(m_kills), 0, 1));

    // Drive the score to 99, then one saturating kill.
    while (m_kills < 99) begin
      model_kill();
      apply(mk($sformatf("kill%0d", m_kills), 0, 1, 0, 0, 90, S_PLAY, m_lives, bcd(m_kills), 0, 1));
    end
    check("score at 99", 32'(score), 32'h99);
    model_kill();
    apply(mk("kill_sat", 0, 1, 0, 0, 90, S_PLAY, m_lives, 8'h99, 0, 1));
`ifdef GSC_BONUS_LIFE_EN
    check("bonus lives capped", 32'(lives), 32'd7);
`else
    check("no bonus lives", 32'(lives), 32'd2);
`endif

    // Remaining deaths down to game over.
    while (m_lives > 3'd1) begin
      m_lives = m_lives - 3'd1;
      apply(mk("tank_death", 0, 0, 1, 0,  0, S_RESP, m_lives, 8'h99, 0, 0));
      apply(mk("respawn",    0, 0, 0, 0, 60, S_PLAY, m_lives, 8'h99, 1, 0));
    end
    apply(mk("last_death", 0, 0, 1, 0, 0, S_OVER, 3'd0, 8'h99, 0, 0));

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // Reset mid-game: immediate return to IDLE, pending AI respawn dropped.
    Reset_n = 1'b0;
    #2;
    check("midrst state", 32'(state), 32'(S_IDLE));
    check("midrst lives", 32'(lives), 0);
    check("midrst score", 32'(score), 0);
    check("midrst p_respawn", 32'(p_respawn), 0);
    check("midrst ai_respawn", 32'(ai_respawn), 0);
    clk_wait(3);
    check("midrst hold play_en", 32'(play_en), 0);
    Reset_n = 1'b1;
    clk_wait(4);
    apply(mk("post_rst_start", 1, 0, 0, 0,  0, S_PLAY, 3'd3, 8'h00, 1, 1));
    apply(mk("post_rst_quiet", 0, 0, 0, 0, 95, S_PLAY, 3'd3, 8'h00, 0, 0));

    check("p_respawn width", 32'(p_wide), 0);
    check("ai_respawn width", 32'(a_wide), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
